// File: rtl/lpc_host_pkg.sv
// ---------------------------------------------------------------------------
// lpc_host_pkg
// Shared constants for the LPC host cycle engine: START / CYCTYPE / SYNC
// nibble codes, response error codes, FSM state encoding and abort length.
// No ports; imported by lpc_host_xfer and lpc_host_wait_timer.
// ---------------------------------------------------------------------------
package lpc_host_pkg;

    typedef logic [3:0] lpc_state_t;
    typedef logic [1:0] lpc_err_t;

    // START nibbles
    localparam logic [3:0] START_TPM = 4'b0101;
    localparam logic [3:0] START_STD = 4'b0000;

    // SYNC nibbles driven by the peripheral
    localparam logic [3:0] SYNC_READY = 4'b0000;
    localparam logic [3:0] SYNC_SHORT = 4'b0101;
    localparam logic [3:0] SYNC_LONG  = 4'b0110;
    localparam logic [3:0] SYNC_ERR   = 4'b1010;

    // Idle / turnaround / abort drive value
    localparam logic [3:0] LAD_IDLE = 4'b1111;

    // Response error codes
    localparam lpc_err_t ERR_OK      = 2'b00;
    localparam lpc_err_t ERR_SYNC    = 2'b01;
    localparam lpc_err_t ERR_TIMEOUT = 2'b10;
    localparam lpc_err_t ERR_TAR     = 2'b11;

    // FSM state encoding (exported on state_o)
    localparam lpc_state_t ST_IDLE      = 4'd0;
    localparam lpc_state_t ST_START     = 4'd1;
    localparam lpc_state_t ST_CYCTYPE   = 4'd2;
    localparam lpc_state_t ST_ADDR      = 4'd3;
    localparam lpc_state_t ST_WDATA     = 4'd4;
    localparam lpc_state_t ST_TAR_H1    = 4'd5;
    localparam lpc_state_t ST_TAR_H2    = 4'd6;
    localparam lpc_state_t ST_SYNC      = 4'd7;
    localparam lpc_state_t ST_RDATA     = 4'd8;
    localparam lpc_state_t ST_TAR_P1    = 4'd9;
    localparam lpc_state_t ST_TAR_P2    = 4'd10;
    localparam lpc_state_t ST_GAP       = 4'd11;
    localparam lpc_state_t ST_ABORT     = 4'd12;
    localparam lpc_state_t ST_ABORT_END = 4'd13;
    localparam lpc_state_t ST_DONE      = 4'd14;

    // Clocks of LFRAME# low with LAD=1111 during an abort
    localparam int ABORT_LEN = 4;

    // CYCTYPE/DIR nibble: {0, mem, write, 0}
    function automatic logic [3:0] cyctype_nibble(input logic mem, input logic write);
        return {1'b0, mem, write, 1'b0};
    endfunction

endpackage

// File: rtl/lpc_host_wait_timer.sv
// ---------------------------------------------------------------------------
// lpc_host_wait_timer
// Counts consecutive short (0101) or long (0110) SYNC wait nibbles. The run
// restarts whenever the wait code changes, and the count is cleared while
// en_i is low (i.e. outside the SYNC phase). timeout_o flags the nibble that
// would exceed SHORT_WAIT_MAX / LONG_WAIT_MAX consecutive waits, in the same
// clock it is sampled, so the FSM can abort without an extra wait cycle.
// Ports:
//   clk_i, nrst_i   clock, asynchronous active-low reset
//   en_i            SYNC phase active; code_i is sampled this clock
//   code_i          LAD nibble sampled from the peripheral
//   timeout_o       current nibble exceeds the wait budget
// ---------------------------------------------------------------------------
module lpc_host_wait_timer
    import lpc_host_pkg::*;
#(
    parameter int SHORT_WAIT_MAX = 8,
    parameter int LONG_WAIT_MAX  = 256
) (
    input  logic       clk_i,
    input  logic       nrst_i,
    input  logic       en_i,
    input  logic [3:0] code_i,
    output logic       timeout_o
);

    localparam int WAIT_MAX = (LONG_WAIT_MAX > SHORT_WAIT_MAX) ? LONG_WAIT_MAX : SHORT_WAIT_MAX;
    // Must hold WAIT_MAX+1, the value seen on the timing-out nibble
    localparam int CW = $clog2(WAIT_MAX + 2);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [CW-1:0] cnt_inc_s;
    logic [3:0]    code_q;
    logic [3:0]    code_d;
    logic          is_short_s;
    logic          is_long_s;

    // Run-length of the current wait code and the timeout decision
    always_comb begin
        is_short_s = (code_i == SYNC_SHORT);
        is_long_s  = (code_i == SYNC_LONG);
        if ((code_i == code_q) && (cnt_q != '0)) begin
            cnt_inc_s = cnt_q + CW'(1);
        end else begin
            cnt_inc_s = CW'(1);
        end
        timeout_o = en_i && ((is_short_s && (cnt_inc_s > CW'(SHORT_WAIT_MAX))) ||
                             (is_long_s  && (cnt_inc_s > CW'(LONG_WAIT_MAX))));
        if (!en_i) begin
            cnt_d  = '0;
            code_d = SYNC_READY;
        end else if (is_short_s || is_long_s) begin
            cnt_d  = cnt_inc_s;
            code_d = code_i;
        end else begin
            cnt_d  = '0;
            code_d = code_i;
        end
    end

    // Wait counter and last-code registers
    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            cnt_q  <= '0;
            code_q <= SYNC_READY;
        end else begin
            cnt_q  <= cnt_d;
            code_q <= code_d;
        end
    end

endmodule

// File: rtl/lpc_host_xfer.sv
// ---------------------------------------------------------------------------
// lpc_host_xfer
// LPC host cycle engine. Accepts a valid/ready request of 1..MAX_BYTES bytes
// and issues consecutive single-byte LPC I/O or memory cycles with an
// incrementing address, then returns a one-clock response with read data and
// an error code. All LPC pins are registered; their next values are decoded
// from the next-state values so each pin changes exactly on the state edge.
// Ports:
//   clk_i, nrst_i                 clock, asynchronous active-low reset
//   req_valid_i / req_ready_o     request handshake (ready only in IDLE)
//   req_write_i, req_mem_i,
//   req_tpm_i, req_addr_i,
//   req_len_i, req_wdata_i        request fields (len = bytes-1)
//   rsp_valid_o                   one-clock response pulse
//   rsp_rdata_o, rsp_err_o        response, held until next acceptance
//   busy_o, state_o               status / debug
//   lpc_lad_o, lpc_lad_oe_o,
//   lpc_lad_i                     LAD drive, enable and sampled value
//   lpc_lframe_o, lpc_lreset_o    LFRAME#, LRESET# (active low)
// ---------------------------------------------------------------------------
module lpc_host_xfer
    import lpc_host_pkg::*;
#(
    parameter int MEM_ADDR_NIBBLES = 8,
    parameter int IO_ADDR_NIBBLES  = 4,
    parameter int MAX_BYTES        = 4,
    parameter int SHORT_WAIT_MAX   = 8,
    parameter int LONG_WAIT_MAX    = 256,
    localparam int AW    = 4 * MEM_ADDR_NIBBLES,
    localparam int DW    = 8 * MAX_BYTES,
    localparam int LEN_W = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1
) (
    input  logic             clk_i,
    input  logic             nrst_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic             req_write_i,
    input  logic             req_mem_i,
    input  logic             req_tpm_i,
    input  logic [AW-1:0]    req_addr_i,
    input  logic [LEN_W-1:0] req_len_i,
    input  logic [DW-1:0]    req_wdata_i,
    output logic             rsp_valid_o,
    output logic [DW-1:0]    rsp_rdata_o,
    output logic [1:0]       rsp_err_o,
    output logic             busy_o,
    output logic [3:0]       state_o,
    output logic [3:0]       lpc_lad_o,
    output logic             lpc_lad_oe_o,
    input  logic [3:0]       lpc_lad_i,
    output logic             lpc_lframe_o,
    output logic             lpc_lreset_o
);

    localparam int IO_W    = 4 * IO_ADDR_NIBBLES;
    localparam int NIB_MAX = (MEM_ADDR_NIBBLES > ABORT_LEN) ? MEM_ADDR_NIBBLES : ABORT_LEN;
    localparam int NIB_W   = $clog2(NIB_MAX);
    // I/O cycles increment and wrap only within the bits actually sent
    localparam logic [AW-1:0] IO_MASK = AW'((64'd1 << IO_W) - 64'd1);

    lpc_state_t       state_q, state_d;
    logic [NIB_W-1:0] nib_q, nib_d;
    logic [LEN_W-1:0] byte_q, byte_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [DW-1:0]    wdata_q, wdata_d;
    logic             write_q, write_d;
    logic             mem_q, mem_d;
    logic             tpm_q, tpm_d;
    lpc_err_t         err_q, err_d;
    logic [DW-1:0]    rdata_q, rdata_d;

    logic [3:0]       lad_q, lad_d;
    logic             oe_q, oe_d;
    logic             lframe_q, lframe_d;
    logic             lreset_q;
    logic             ready_q;
    logic             rsp_valid_q;
    logic             busy_q;

    logic             sync_active_s;
    logic             wait_timeout_s;
    logic [AW-1:0]    addr_inc_s;
    logic [AW-1:0]    addr_next_s;
    logic [LEN_W+2:0] rd_shift_s;
    lpc_state_t       data_state_s;

    lpc_host_wait_timer #(
        .SHORT_WAIT_MAX (SHORT_WAIT_MAX),
        .LONG_WAIT_MAX  (LONG_WAIT_MAX)
    ) u_wait_timer (
        .clk_i     (clk_i),
        .nrst_i    (nrst_i),
        .en_i      (sync_active_s),
        .code_i    (lpc_lad_i),
        .timeout_o (wait_timeout_s)
    );

    // Helper values: address stepping, read-data nibble slot, post-SYNC state
    always_comb begin
        sync_active_s = (state_q == ST_SYNC);
        addr_inc_s    = addr_q + AW'(1);
        if (mem_q) begin
            addr_next_s = addr_inc_s;
        end else begin
            addr_next_s = (addr_q & ~IO_MASK) | (addr_inc_s & IO_MASK);
        end
        rd_shift_s = {byte_q, nib_q[0], 2'b00};
        if (write_q) begin
            data_state_s = ST_TAR_P1;
        end else begin
            data_state_s = ST_RDATA;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        nib_d   = nib_q;
        byte_d  = byte_q;
        len_d   = len_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        write_d = write_q;
        mem_d   = mem_q;
        tpm_d   = tpm_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid_i && ready_q) begin
                    state_d = ST_START;
                    nib_d   = '0;
                    byte_d  = '0;
                    len_d   = req_len_i;
                    addr_d  = req_addr_i;
                    wdata_d = req_wdata_i;
                    write_d = req_write_i;
                    mem_d   = req_mem_i;
                    tpm_d   = req_tpm_i;
                    err_d   = ERR_OK;
                    rdata_d = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: state_d = ST_CYCTYPE;
            ST_CYCTYPE: begin
                state_d = ST_ADDR;
                if (mem_q) begin
                    nib_d = NIB_W'(MEM_ADDR_NIBBLES - 1);
                end else begin
                    nib_d = NIB_W'(IO_ADDR_NIBBLES - 1);
                end
            end
            ST_ADDR: begin
                if (nib_q == '0) begin
                    if (write_q) begin
                        state_d = ST_WDATA;
                    end else begin
                        state_d = ST_TAR_H1;
                    end
                end else begin
                    nib_d = nib_q - NIB_W'(1);
                end
            end
            ST_WDATA: begin
                if (nib_q[0]) begin
                    state_d = ST_TAR_H1;
                    nib_d   = '0;
                end else begin
                    nib_d = NIB_W'(1);
                end
            end
            ST_TAR_H1: state_d = ST_TAR_H2;
            ST_TAR_H2: state_d = ST_SYNC;
            ST_SYNC: begin
                nib_d = '0;
                case (lpc_lad_i)
                    SYNC_READY: state_d = data_state_s;
                    // Error SYNC still completes the data phase of this byte
                    SYNC_ERR: begin
                        err_d   = ERR_SYNC;
                        state_d = data_state_s;
                    end
                    SYNC_SHORT, SYNC_LONG: begin
                        if (wait_timeout_s) begin
                            err_d   = ERR_TIMEOUT;
                            state_d = ST_ABORT;
                        end else begin
                            state_d = ST_SYNC;
                        end
                    end
                    default: begin
                        err_d   = ERR_TIMEOUT;
                        state_d = ST_ABORT;
                    end
                endcase
            end
            ST_RDATA: begin
                rdata_d = (rdata_q & ~(DW'(4'hF) << rd_shift_s)) | (DW'(lpc_lad_i) << rd_shift_s);
                if (nib_q[0]) begin
                    state_d = ST_TAR_P1;
                    nib_d   = '0;
                end else begin
                    nib_d = NIB_W'(1);
                end
            end
            // Peripheral must release LAD to 1111; anything else is flagged, not aborted
            ST_TAR_P1: begin
                state_d = ST_TAR_P2;
                if (lpc_lad_i != LAD_IDLE) begin
                    err_d = ERR_TAR;
                end else begin
                    err_d = err_q;
                end
            end
            ST_TAR_P2: begin
                if ((err_q != ERR_OK) || (byte_q == len_q)) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_GAP;
                    byte_d  = byte_q + LEN_W'(1);
                    addr_d  = addr_next_s;
                end
            end
            ST_GAP: state_d = ST_START;
            ST_ABORT: begin
                if (nib_q == NIB_W'(ABORT_LEN - 1)) begin
                    state_d = ST_ABORT_END;
                    nib_d   = '0;
                end else begin
                    nib_d = nib_q + NIB_W'(1);
                end
            end
            ST_ABORT_END: state_d = ST_DONE;
            ST_DONE:      state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    // LAD / LFRAME# / OE decode for the state being entered
    always_comb begin
        lad_d    = LAD_IDLE;
        oe_d     = 1'b0;
        lframe_d = 1'b1;
        case (state_d)
            ST_START: begin
                lframe_d = 1'b0;
                oe_d     = 1'b1;
                if (tpm_d) begin
                    lad_d = START_TPM;
                end else begin
                    lad_d = START_STD;
                end
            end
            ST_CYCTYPE: begin
                oe_d  = 1'b1;
                lad_d = cyctype_nibble(mem_d, write_d);
            end
            ST_ADDR: begin
                oe_d  = 1'b1;
                lad_d = 4'(addr_d >> {nib_d, 2'b00});
            end
            ST_WDATA: begin
                oe_d  = 1'b1;
                lad_d = 4'(wdata_d >> {byte_d, nib_d[0], 2'b00});
            end
            ST_TAR_H1: begin
                oe_d  = 1'b1;
                lad_d = LAD_IDLE;
            end
            ST_ABORT: begin
                lframe_d = 1'b0;
                oe_d     = 1'b1;
                lad_d    = LAD_IDLE;
            end
            default: begin
                lad_d    = LAD_IDLE;
                oe_d     = 1'b0;
                lframe_d = 1'b1;
            end
        endcase
    end

    // State, datapath and registered output flops
    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            state_q     <= ST_IDLE;
            nib_q       <= '0;
            byte_q      <= '0;
            len_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            write_q     <= 1'b0;
            mem_q       <= 1'b0;
            tpm_q       <= 1'b0;
            err_q       <= ERR_OK;
            rdata_q     <= '0;
            lad_q       <= LAD_IDLE;
            oe_q        <= 1'b0;
            lframe_q    <= 1'b1;
            lreset_q    <= 1'b0;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            nib_q       <= nib_d;
            byte_q      <= byte_d;
            len_q       <= len_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            write_q     <= write_d;
            mem_q       <= mem_d;
            tpm_q       <= tpm_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            lad_q       <= lad_d;
            oe_q        <= oe_d;
            lframe_q    <= lframe_d;
            lreset_q    <= 1'b1;
            ready_q     <= (state_d == ST_IDLE);
            rsp_valid_q <= (state_d == ST_DONE);
            busy_q      <= (state_d != ST_IDLE);
        end
    end

    assign req_ready_o  = ready_q;
    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_rdata_o  = rdata_q;
    assign rsp_err_o    = err_q;
    assign busy_o       = busy_q;
    assign state_o      = state_q;
    assign lpc_lad_o    = lad_q;
    assign lpc_lad_oe_o = oe_q;
    assign lpc_lframe_o = lframe_q;
    assign lpc_lreset_o = lreset_q;

endmodule

// File: tb/tb_lpc_host_xfer.sv
// ---------------------------------------------------------------------------
// tb_lpc_host_xfer
// Self-checking bench for lpc_host_xfer. For every request a reference model
// expands the LPC protocol rules into a per-clock list of expected host pin
// values and peripheral LAD drive, plus the expected response.
// ---------------------------------------------------------------------------
module tb_lpc_host_xfer;

    localparam int SHORT_MAX = 8;
    localparam int LONG_MAX  = 256;
    localparam int SLOTS     = 300;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic        req_mem = 1'b0;
    logic        req_tpm = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [1:0]  req_len = 2'd0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_err;
    logic        busy;
    logic [3:0]  state;
    logic [3:0]  lad_o;
    logic        lad_oe;
    logic [3:0]  lad_i = 4'hF;
    logic        lframe;
    logic        lreset;

    int total = 0;
    int bad   = 0;

    // Transaction description
    bit          t_write, t_mem, t_tpm;
    logic [31:0] t_addr, t_wdata;
    int          t_len;
    logic [3:0]  sync_s [4][SLOTS];
    int          sync_len [4];
    logic [7:0]  rd_byte [4];
    logic [3:0]  tar_nib [4];

    // Expected per-clock trace
    bit          e_fr[$];
    bit          e_oe[$];
    logic [3:0]  e_lad[$];
    logic [3:0]  e_drv[$];

    always #5 clk = ~clk;

    lpc_host_xfer dut (
        .clk_i        (clk),
        .nrst_i       (nrst),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_write_i  (req_write),
        .req_mem_i    (req_mem),
        .req_tpm_i    (req_tpm),
        .req_addr_i   (req_addr),
        .req_len_i    (req_len),
        .req_wdata_i  (req_wdata),
        .rsp_valid_o  (rsp_valid),
        .rsp_rdata_o  (rsp_rdata),
        .rsp_err_o    (rsp_err),
        .busy_o       (busy),
        .state_o      (state),
        .lpc_lad_o    (lad_o),
        .lpc_lad_oe_o (lad_oe),
        .lpc_lad_i    (lad_i),
        .lpc_lframe_o (lframe),
        .lpc_lreset_o (lreset)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push(input bit fr, input bit oe, input logic [3:0] lad, input logic [3:0] drv);
        e_fr.push_back(fr);
        e_oe.push_back(oe);
        e_lad.push_back(lad);
        e_drv.push_back(drv);
    endtask

    task automatic add_sync(input int b, input logic [3:0] code, input int n);
        for (int i = 0; i < n; i++) begin
            sync_s[b][sync_len[b]] = code;
            sync_len[b] = sync_len[b] + 1;
        end
    endtask

    task automatic clear_scripts();
        for (int b = 0; b < 4; b++) begin
            sync_len[b] = 0;
            rd_byte[b]  = 8'($urandom);
            tar_nib[b]  = 4'hF;
        end
    endtask

    // Reference model: expand the request into the expected pin trace
    task automatic build_model(output logic [31:0] erd, output logic [1:0] eerr);
        int          n;
        logic [31:0] a;
        logic [7:0]  wb;
        logic [3:0]  s;
        logic [3:0]  last;
        int          cnt;
        bit          aborted;
        e_fr.delete(); e_oe.delete(); e_lad.delete(); e_drv.delete();
        erd  = 32'h0;
        eerr = 2'b00;
        n    = t_mem ? 8 : 4;
        for (int b = 0; b <= t_len; b++) begin
            a = t_mem ? (t_addr + b) : ((t_addr + b) & 32'h0000_FFFF);
            push(1'b0, 1'b1, t_tpm ? 4'h5 : 4'h0, 4'hF);
            push(1'b1, 1'b1, {1'b0, t_mem, t_write, 1'b0}, 4'hF);
            for (int i = n - 1; i >= 0; i--) push(1'b1, 1'b1, a[4*i +: 4], 4'hF);
            if (t_write) begin
                wb = t_wdata[8*b +: 8];
                push(1'b1, 1'b1, wb[3:0], 4'hF);
                push(1'b1, 1'b1, wb[7:4], 4'hF);
            end
            push(1'b1, 1'b1, 4'hF, 4'hF);
            push(1'b1, 1'b0, 4'hF, 4'hF);
            cnt = 0; last = 4'h0; aborted = 1'b0;
            for (int i = 0; i < sync_len[b]; i++) begin
                s = sync_s[b][i];
                push(1'b1, 1'b0, 4'hF, s);
                if (s == 4'h0) break;
                else if (s == 4'hA) begin eerr = 2'b01; break; end
                else if (s == 4'h5 || s == 4'h6) begin
                    if (cnt > 0 && s == last) cnt++; else cnt = 1;
                    last = s;
                    if ((s == 4'h5 && cnt > SHORT_MAX) || (s == 4'h6 && cnt > LONG_MAX)) begin
                        aborted = 1'b1; break;
                    end
                end else begin aborted = 1'b1; break; end
            end
            if (aborted) begin
                eerr = 2'b10;
                for (int i = 0; i < 4; i++) push(1'b0, 1'b1, 4'hF, 4'hF);
                push(1'b1, 1'b0, 4'hF, 4'hF);
                break;
            end
            if (!t_write) begin
                push(1'b1, 1'b0, 4'hF, rd_byte[b][3:0]);
                push(1'b1, 1'b0, 4'hF, rd_byte[b][7:4]);
                erd[8*b +: 8] = rd_byte[b];
            end
            push(1'b1, 1'b0, 4'hF, tar_nib[b]);
            if (tar_nib[b] != 4'hF) eerr = 2'b11;
            push(1'b1, 1'b0, 4'hF, 4'hF);
            if (eerr != 2'b00) break;
            if (b < t_len) push(1'b1, 1'b0, 4'hF, 4'hF);
        end
    endtask

    task automatic issue_req();
        int w = 0;
        while (req_ready !== 1'b1 && w < 8) begin
            @(negedge clk);
            w++;
        end
        chk("ready_wait", req_ready, 1'b1);
        req_write = t_write; req_mem = t_mem; req_tpm = t_tpm;
        req_addr = t_addr; req_len = 2'(t_len); req_wdata = t_wdata;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic run_xfer(input string nm);
        logic [31:0] erd;
        logic [1:0]  eerr;
        build_model(erd, eerr);
        issue_req();
        chk({nm, "_ready_drop"}, req_ready, 1'b0);
        chk({nm, "_rdata_clr"}, rsp_rdata, 32'h0);
        chk({nm, "_err_clr"}, rsp_err, 2'b00);
        for (int k = 0; k < e_fr.size(); k++) begin
            chk($sformatf("%s_lframe%0d", nm, k), lframe, e_fr[k]);
            chk($sformatf("%s_oe%0d", nm, k), lad_oe, e_oe[k]);
            if (e_oe[k]) chk($sformatf("%s_lad%0d", nm, k), lad_o, e_lad[k]);
            chk($sformatf("%s_vld%0d", nm, k), rsp_valid, 1'b0);
            lad_i = e_drv[k];
            @(negedge clk);
        end
        lad_i = 4'hF;
        chk({nm, "_rsp_valid"}, rsp_valid, 1'b1);
        chk({nm, "_rdata"}, rsp_rdata, erd);
        chk({nm, "_err"}, rsp_err, eerr);
        chk({nm, "_busy_done"}, busy, 1'b1);
        @(negedge clk);
        chk({nm, "_vld_drop"}, rsp_valid, 1'b0);
        chk({nm, "_ready_back"}, req_ready, 1'b1);
        chk({nm, "_busy_idle"}, busy, 1'b0);
        chk({nm, "_rdata_hold"}, rsp_rdata, erd);
        chk({nm, "_err_hold"}, rsp_err, eerr);
    endtask

    task automatic set_req(input bit w, input bit m, input bit tp, input logic [31:0] a,
                           input int len, input logic [31:0] wd);
        t_write = w; t_mem = m; t_tpm = tp; t_addr = a; t_len = len; t_wdata = wd;
        clear_scripts();
        for (int b = 0; b < 4; b++) add_sync(b, 4'h0, 1);
    endtask

    initial begin
        logic [3:0] v;
        int         mode;
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_lreset", lreset, 1'b0);
        chk("rst_lframe", lframe, 1'b1);
        chk("rst_oe", lad_oe, 1'b0);
        chk("rst_lad", lad_o, 4'hF);
        chk("rst_ready", req_ready, 1'b0);
        chk("rst_valid", rsp_valid, 1'b0);
        chk("rst_rdata", rsp_rdata, 32'h0);
        chk("rst_err", rsp_err, 2'b00);
        chk("rst_busy", busy, 1'b0);
        nrst = 1'b1;
        @(posedge clk); #1;
        chk("rel_lreset", lreset, 1'b1);
        chk("rel_ready", req_ready, 1'b1);
        @(negedge clk);

        // I/O read 0x0080, TPM start, data 0x5A
        set_req(1'b0, 1'b0, 1'b1, 32'h0000_0080, 0, 32'h0);
        rd_byte[0] = 8'h5A;
        run_xfer("io_rd");

        // Memory write, 4 bytes
        set_req(1'b1, 1'b1, 1'b0, 32'hFED4_0000, 3, 32'h4433_2211);
        run_xfer("mem_wr4");

        // Long waits then ready
        set_req(1'b0, 1'b0, 1'b0, 32'h0000_1234, 0, 32'h0);
        sync_len[0] = 0; add_sync(0, 4'h6, 3); add_sync(0, 4'h0, 1);
        run_xfer("long3");

        // Exactly SHORT_MAX short waits is still fine
        set_req(1'b0, 1'b0, 1'b0, 32'h0000_0060, 0, 32'h0);
        sync_len[0] = 0; add_sync(0, 4'h5, 8); add_sync(0, 4'h0, 1);
        run_xfer("short8");

        // One more short wait times out and aborts
        set_req(1'b0, 1'b0, 1'b0, 32'h0000_0060, 0, 32'h0);
        sync_len[0] = 0; add_sync(0, 4'h5, 9); add_sync(0, 4'h0, 1);
        run_xfer("short9");

        // Long wait boundary: 256 ok, 257 aborts
        set_req(1'b1, 1'b0, 1'b0, 32'h0000_0070, 0, 32'h0000_00C3);
        sync_len[0] = 0; add_sync(0, 4'h6, 256); add_sync(0, 4'h0, 1);
        run_xfer("long256");
        set_req(1'b1, 1'b0, 1'b0, 32'h0000_0070, 0, 32'h0000_00C3);
        sync_len[0] = 0; add_sync(0, 4'h6, 257); add_sync(0, 4'h0, 1);
        run_xfer("long257");

        // Error SYNC on byte 1 of a 4-byte read
        set_req(1'b0, 1'b1, 1'b1, 32'h1000_0000, 3, 32'h0);
        sync_len[1] = 0; add_sync(1, 4'hA, 1);
        run_xfer("sync_err");

        // Bad peripheral turnaround on a write
        set_req(1'b1, 1'b0, 1'b0, 32'h0000_0080, 1, 32'h0000_BEEF);
        tar_nib[0] = 4'h0;
        run_xfer("bad_tar");

        // Address wrap: I/O within 16 bits, memory within 32 bits
        set_req(1'b0, 1'b0, 1'b0, 32'hABCD_FFFF, 1, 32'h0);
        run_xfer("io_wrap");
        set_req(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFE, 3, 32'h8765_4321);
        run_xfer("mem_wrap");

        // Reset during ADDR
        set_req(1'b0, 1'b0, 1'b0, 32'h0000_0080, 0, 32'h0);
        issue_req();
        repeat (2) @(negedge clk);
        #2 nrst = 1'b0;
        #1;
        chk("mid_rst_lreset", lreset, 1'b0);
        chk("mid_rst_lframe", lframe, 1'b1);
        chk("mid_rst_oe", lad_oe, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_valid", rsp_valid, 1'b0);
        @(negedge clk);
        nrst = 1'b1;
        @(posedge clk); #1;
        chk("mid_rel_lreset", lreset, 1'b1);
        chk("mid_rel_ready", req_ready, 1'b1);
        chk("mid_rel_valid", rsp_valid, 1'b0);
        @(negedge clk);
        set_req(1'b0, 1'b0, 1'b1, 32'h0000_0081, 0, 32'h0);
        run_xfer("post_rst");

        // Randomized requests
        for (int n = 0; n < 60; n++) begin
            set_req(1'($urandom), 1'($urandom), 1'($urandom), $urandom,
                    $urandom_range(0, 3), $urandom);
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 9) == 0) tar_nib[b] = 4'h0;
                mode = $urandom_range(0, 9);
                sync_len[b] = 0;
                case (mode)
                    5: add_sync(b, 4'h5, $urandom_range(0, 9));
                    6: add_sync(b, 4'h6, $urandom_range(0, 12));
                    7: begin
                        add_sync(b, 4'h5, $urandom_range(1, 8));
                        add_sync(b, 4'h6, $urandom_range(1, 8));
                        add_sync(b, 4'h5, $urandom_range(1, 8));
                    end
                    default: ;
                endcase
                if (mode == 8) begin
                    add_sync(b, 4'hA, 1);
                end else if (mode == 9) begin
                    v = 4'($urandom_range(1, 15));
                    if (v == 4'h5 || v == 4'h6 || v == 4'hA) v = 4'h3;
                    add_sync(b, v, 1);
                end else begin
                    add_sync(b, 4'h0, 1);
                end
            end
            run_xfer($sformatf("rnd%0d", n));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
